// File: rtl/lfsr_sched.sv
// Round-robin scheduler sharing one 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1)
// between two requesters; each grant advances the LFSR STEPS times.
module lfsr_sched #(
  parameter int unsigned STEPS = 8,
  parameter logic [7:0]  SEED  = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       seed_valid,
  input  logic [7:0] seed_data,
  output logic       seed_ready,
  input  logic [1:0] req,
  output logic [1:0] ack,
  output logic [7:0] rnd_data,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, STEP, RESP} state_t;

  localparam logic [7:0] LAST_CNT = 8'(STEPS - 1);

  state_t     state, state_n;
  logic [7:0] lfsr, lfsr_n, lfsr_adv;
  logic [7:0] cnt, cnt_n;
  logic [7:0] rnd_n;
  logic [1:0] ack_n;
  logic       id, id_n;
  logic       last, last_n;
  logic       winner;

  assign lfsr_adv = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  // On a tie the requester not granted last wins; otherwise the lone requester.
  assign winner   = (req == 2'b11) ? ~last : req[1];

  assign seed_ready = (state == IDLE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lfsr     <= SEED;
      cnt      <= '0;
      id       <= 1'b0;
      last     <= 1'b1;
      ack      <= '0;
      rnd_data <= '0;
    end else begin
      state    <= state_n;
      lfsr     <= lfsr_n;
      cnt      <= cnt_n;
      id       <= id_n;
      last     <= last_n;
      ack      <= ack_n;
      rnd_data <= rnd_n;
    end
  end

  always_comb begin
    state_n = state;
    lfsr_n  = lfsr;
    cnt_n   = cnt;
    id_n    = id;
    last_n  = last;
    ack_n   = '0;
    rnd_n   = rnd_data;
    case (state)
      IDLE: begin
        if (seed_valid) begin
          lfsr_n = (seed_data == 8'h00) ? 8'h01 : seed_data;
        end else if (req != 2'b00) begin
          id_n    = winner;
          cnt_n   = '0;
          state_n = STEP;
        end
      end
      STEP: begin
        lfsr_n = lfsr_adv;
        cnt_n  = cnt + 8'd1;
        // ack/rnd_data are loaded on the final advance so they are valid in RESP.
        if (cnt == LAST_CNT) begin
          state_n = RESP;
          ack_n   = id ? 2'b10 : 2'b01;
          rnd_n   = lfsr_adv;
        end
      end
      RESP: begin
        last_n  = id;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lfsr_sched.sv
// Directed bench for lfsr_sched: one instance with STEPS=8, one with STEPS=1.
module tb_lfsr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       s8_valid, s1_valid;
  logic [7:0] s8_data, s1_data;
  logic       s8_ready, s1_ready;
  logic [1:0] req8, req1, ack8, ack1;
  logic [7:0] rnd8, rnd1;
  logic       busy8, busy1;

  int checks = 0;
  int fails  = 0;

  logic [7:0] m8, m1;
  int         n;
  logic [1:0] a;
  logic [7:0] r;

  always #5 clk = ~clk;

  lfsr_sched #(.STEPS(8), .SEED(8'h01)) dut8 (
    .clk(clk), .rst(rst), .seed_valid(s8_valid), .seed_data(s8_data),
    .seed_ready(s8_ready), .req(req8), .ack(ack8), .rnd_data(rnd8), .busy(busy8)
  );

  lfsr_sched #(.STEPS(1), .SEED(8'h01)) dut1 (
    .clk(clk), .rst(rst), .seed_valid(s1_valid), .seed_data(s1_data),
    .seed_ready(s1_ready), .req(req1), .ack(ack1), .rnd_data(rnd1), .busy(busy1)
  );

  function automatic logic [7:0] adv(input logic [7:0] x, input int unsigned k);
    logic [7:0] v;
    v = x;
    for (int unsigned i = 0; i < k; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit which, output int cnt, output logic [1:0] ak, output logic [7:0] rd);
    cnt = 0;
    ak  = '0;
    rd  = '0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if ((which ? ack1 : ack8) != 2'b00) begin
        cnt = i;
        ak  = which ? ack1 : ack8;
        rd  = which ? rnd1 : rnd8;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    s8_valid = 1'b0; s8_data = '0; req8 = '0;
    s1_valid = 1'b0; s1_data = '0; req1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ack", 32'(ack8), 32'h0);
    check("reset_rnd", 32'(rnd8), 32'h0);
    check("reset_busy", 32'(busy8), 32'h0);
    check("reset_ready", 32'(s8_ready), 32'h1);
    rst = 1'b0;
    m8 = 8'h01;
    m1 = 8'h01;
    tick();

    // Single requester, STEPS=8
    req8 = 2'b01;
    wait_ack(1'b0, n, a, r);
    check("t1_latency", 32'(n), 32'd9);
    check("t1_ack", 32'(a), 32'h1);
    check("t1_rnd", 32'(r), 32'h1C);
    m8 = adv(m8, 8);
    req8 = 2'b00;
    tick();
    check("t1_ack_pulse", 32'(ack8), 32'h0);
    check("t1_rnd_hold", 32'(rnd8), 32'h1C);

    // Both requesting: alternation starting with requester 1
    req8 = 2'b11;
    wait_ack(1'b0, n, a, r);
    m8 = adv(m8, 8);
    check("t2_latency0", 32'(n), 32'd9);
    check("t2_ack0", 32'(a), 32'h2);
    check("t2_rnd0", 32'(r), 32'h4B);
    for (int k = 1; k <= 4; k++) begin
      wait_ack(1'b0, n, a, r);
      m8 = adv(m8, 8);
      check("t2_latency", 32'(n), 32'd10);
      check("t2_ack", 32'(a), (k % 2 == 1) ? 32'h1 : 32'h2);
      check("t2_rnd", 32'(r), 32'(m8));
    end
    req8 = 2'b00;
    tick();

    // Seed with zero substitution, STEPS=1
    s1_valid = 1'b1; s1_data = 8'h00;
    tick();
    s1_valid = 1'b0;
    req1 = 2'b01;
    wait_ack(1'b1, n, a, r);
    check("t3_latency", 32'(n), 32'd2);
    check("t3_rnd_zero_seed", 32'(r), 32'h02);
    req1 = 2'b00;
    tick();
    s1_valid = 1'b1; s1_data = 8'h80;
    tick();
    s1_valid = 1'b0;
    req1 = 2'b01;
    wait_ack(1'b1, n, a, r);
    check("t3_rnd_seed80", 32'(r), 32'h01);
    req1 = 2'b00;
    tick();

    // Seed and request together: seed wins, grant follows
    s1_valid = 1'b1; s1_data = 8'h5A; req1 = 2'b01;
    tick();
    check("t4_ready", 32'(s1_ready), 32'h1);
    check("t4_busy", 32'(busy1), 32'h0);
    check("t4_no_ack", 32'(ack1), 32'h0);
    s1_valid = 1'b0;
    wait_ack(1'b1, n, a, r);
    check("t4_latency", 32'(n), 32'd2);
    check("t4_rnd", 32'(r), 32'hB4);
    req1 = 2'b00;
    tick();

    // Seed pulse during STEP is ignored; dropped request still acked
    req8 = 2'b10;
    tick();
    check("t5_busy", 32'(busy8), 32'h1);
    check("t5_ready", 32'(s8_ready), 32'h0);
    s8_valid = 1'b1; s8_data = 8'hFF; req8 = 2'b00;
    tick();
    tick();
    s8_valid = 1'b0;
    wait_ack(1'b0, n, a, r);
    m8 = adv(m8, 8);
    check("t5_latency", 32'(n), 32'd6);
    check("t5_ack", 32'(a), 32'h2);
    check("t5_rnd", 32'(r), 32'(m8));
    tick();

    // Async reset mid-STEP
    req8 = 2'b01;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("t6_ack", 32'(ack8), 32'h0);
    check("t6_busy", 32'(busy8), 32'h0);
    check("t6_ready", 32'(s8_ready), 32'h1);
    check("t6_rnd", 32'(rnd8), 32'h0);
    tick();
    rst = 1'b0;
    wait_ack(1'b0, n, a, r);
    check("t6_latency", 32'(n), 32'd9);
    check("t6_rnd", 32'(r), 32'h1C);
    req8 = 2'b00;
    tick();

    // Full period with STEPS=1 (dut1 was reset to 01 above)
    m1 = 8'h01;
    req1 = 2'b01;
    for (int k = 1; k <= 255; k++) begin
      wait_ack(1'b1, n, a, r);
      m1 = adv(m1, 1);
      check("t7_latency", 32'(n), (k == 1) ? 32'd2 : 32'd3);
      check("t7_rnd", 32'(r), 32'(m1));
    end
    check("t7_period", 32'(r), 32'h01);
    req1 = 2'b00;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule

// File: doc/lfsr_sched.md
# lfsr_sched

Request scheduler and owner of the team's 8-bit Fibonacci LFSR random source (polynomial x^8+x^6+x^5+x^4+1). It shares one LFSR between two requesters with round-robin arbitration. Each granted request advances the LFSR STEPS times before the value is returned, so consecutive consumers get decorrelated values. It also provides a seed-load port so software or test logic can reseed the generator between requests.

## Interface
- STEPS, 8, LFSR advances per served request; legal range 1..255.
- SEED, 8'h01, LFSR reset value; must be nonzero.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- seed_valid  in  1  load request for seed_data; accepted only when seed_ready=1.
- seed_data  in  8  new LFSR state.
- seed_ready  out  1  high when the FSM is in IDLE.
- req  in  2  req[i] high = requester i wants a value; held until ack[i].
- ack  out  2  one-cycle grant/response pulse; at most one bit set.
- rnd_data  out  8  random value, valid while any ack bit is high; holds its last value otherwise.
- busy  out  1  high in STEP and RESP.

## Operation
- LFSR step rule: next = {r[6:0], r[7]^r[5]^r[4]^r[3]}. This gives a maximal period of 255 over the nonzero states.
- FSM states:
  - IDLE: seed_ready=1.
    - If seed_valid: load seed_data into the LFSR, substituting 8'h01 when seed_data==0. Stay in IDLE. Requests are not granted that cycle; seed has priority.
    - Else if req!=0: pick a winner, latch winner id, clear step counter, go to STEP.
  - STEP: LFSR advances once per cycle and the counter increments. When counter==STEPS-1, go to RESP. Exactly STEPS advances occur in total.
  - RESP: ack[id]=1 and rnd_data=current LFSR value, both registered. Update last-grant pointer to id. Return to IDLE. The LFSR does not advance.
- Arbitration:
  - If only one requester is active, it wins.
  - If both are active, the one not granted last wins.
  - The last-grant pointer resets to 1, so req0 wins the first tie.
- seed_valid outside IDLE is ignored; the source must hold it until seed_ready.
- If req[i] drops during STEP, service still completes and ack[i] still pulses. The LFSR state is consumed either way.
- If req[i] stays high after ack, it is re-arbitrated in the following IDLE cycle.
- Zero state is unreachable: reset value and seed substitution both guarantee a nonzero state.

## Timing
- Reset (async assert, outputs valid immediately):
  - LFSR=SEED, state=IDLE, counter=0, pointer=1.
  - ack=0, rnd_data=8'h00, busy=0, seed_ready=1.
- Request latency, with cycle 0 = the edge where IDLE samples req:
  - STEP occupies cycles 1..STEPS.
  - ack is high during cycle STEPS+1.
  - Next IDLE is cycle STEPS+2.
- Throughput: one served request per STEPS+2 cycles. Back-to-back requests always pass through one IDLE cycle.
- Seed load takes effect on the edge where it is sampled; the next cycle is still IDLE.
- Reset mid-STEP or mid-RESP: immediate return to reset values. Any pending ack is lost.

## Test plan
- Reset, STEPS=8, pulse req=2'b01 held until ack:
  - ack=2'b01 exactly 9 cycles after the request edge, with rnd_data=8'h1C.
  - The intermediate LFSR sequence is 02,04,08,11,23,47,8E,1C.
- Continuing from that test, req=2'b11 held high:
  - First grant goes to requester 1 with rnd_data=8'h4B.
  - Next grant goes to requester 0.
  - Grants alternate thereafter; ack is never 2'b11.
- Seed with STEPS=1:
  - seed_valid=1, seed_data=8'h00 in IDLE, then req=2'b01 → rnd_data=8'h02 (zero substituted by 01).
  - Reseed 8'h80 → next rnd_data=8'h01.
- Seed collision: seed_valid and req both asserted in IDLE → seed loaded first, seed_ready=1 that cycle; grant issued on the following IDLE cycle.
- Ignored seed and dropped request: seed_valid pulsed during STEP is ignored (data unchanged vs. a golden model). A request dropped mid-STEP still receives ack.
- Async reset and period check:
  - Assert rst during STEP → ack=0, busy=0, seed_ready=1 without waiting for a clock edge. A subsequent request yields 8'h1C again (STEPS=8).
  - With STEPS=1, 255 consecutive served requests return rnd_data to 8'h01.
